alu_result_fifo: RTL and testbench
==================================

Name: alu_result_fifo

Overview:
Downstream capture stage for the combinational ALU, which produces sum, dif, pro, quo, rem, and, or and xor results.
- On each accepted command, selects one of the eight 32-bit ALU results by opcode and flags divide-by-zero.
- Pushes {op, err, data} into a DEPTH-entry FIFO.
- Presents FIFO entries to the consumer over a valid/ready interface, decoupling the combinational ALU from a back-pressured sink.

Parameters:
DW, 32, width of each ALU result and of res_data
DEPTH, 4, FIFO entries; power of 2, minimum 2
AW, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  ALU outputs and cmd_op valid this cycle
cmd_ready  output  1  block can accept a command this cycle
cmd_op  input  3  result select: 0 sum, 1 dif, 2 pro, 3 quo, 4 rem, 5 and, 6 or, 7 xor
div_b  input  31  divisor operand fed to the ALU (divide-by-zero check only)
sum_i, dif_i, pro_i, quo_i, rem_i, and_i, or_i, xor_i  input  DW each  ALU result buses
res_valid  output  1  head entry available
res_ready  input  1  consumer accepts head entry
res_data  output  DW  head entry data
res_op  output  3  head entry opcode
res_err  output  1  head entry divide-by-zero flag
fifo_count  output  AW+1  entries currently stored, 0..DEPTH
accept_cnt  output  16  total commands accepted since reset

Behaviour:
- Reset (async assert, synchronous release on clk): write pointer, read pointer, fifo_count and accept_cnt = 0; res_valid = 0, cmd_ready = 1. res_data, res_op and res_err read 0 while empty.
- Push: push = cmd_valid && cmd_ready.
  - Stores op = cmd_op.
  - err = (cmd_op == 3 || cmd_op == 4) && (div_b == 0).
  - data = selected result bus, forced to 0 when err = 1.
  - ALU inputs are sampled only at the push edge.
- Pop: pop = res_valid && res_ready. Read pointer advances on the edge.
- res_valid = (fifo_count != 0). res_data, res_op and res_err come combinationally from storage at the read pointer.
  - No combinational path from cmd_* to res_*. Write-to-read latency is 1 cycle: an entry pushed at edge N is visible after edge N.
- cmd_ready = (fifo_count < DEPTH) || res_ready.
  - When full, a push is allowed in the same cycle as a pop.
  - res_ready→cmd_ready is the only combinational path.
- fifo_count updates:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged
  - neither: unchanged
- Pointers wrap modulo DEPTH.
- Empty: pop cannot occur (res_valid = 0). Push and pop in the same cycle when empty is impossible; the push alone is performed.
- Full: a push without a simultaneous pop is impossible (cmd_ready = 0). cmd_valid held high while cmd_ready = 0 is ignored, with no state change.
- Order: strictly FIFO.
- Stability: the head entry's outputs are stable while res_valid = 1 and res_ready = 0.
- accept_cnt increments by 1 on each push and wraps from 0xFFFF to 0x0000.
- Reset mid-operation: all stored entries are discarded immediately and outputs return to reset values asynchronously. No partial push or pop completes.
- Storage array has no reset requirement. Its contents are unobservable while res_valid = 0.

Test Plan:
- Reset, then push op=0 with sum_i=32'h0000_0007 and res_ready=0 → after 1 edge: res_valid=1, res_data=7, res_op=0, res_err=0, fifo_count=1, accept_cnt=1.
- Push op=3 with div_b=0 and quo_i=32'hDEAD_BEEF → entry res_err=1, res_data=0. Same with op=5, div_b=0, and_i=32'hF0F0_F0F0 → res_err=0, res_data=F0F0_F0F0.
- Hold res_ready=0 and push 5 commands with cmd_valid held high → 4 accepted, then cmd_ready=0 and fifo_count=4. The 5th is accepted only in the cycle res_ready=1, with fifo_count staying 4. Drained data returns in push order.
- With the FIFO full, drive res_ready=1 and cmd_valid=1 for 8 cycles → 8 pushes and 8 pops, fifo_count constant at 4, pointers wrap twice with no corruption.
- Assert rst_n=0 mid-stream with fifo_count=3 → res_valid=0 and fifo_count=0 without waiting for a clock edge. After release, the next push is the only entry.
- Issue 65537 pushes with res_ready=1 → accept_cnt=1 (wrap verified).

Source files
------------

// File: rtl/alu_result_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_result_fifo_if
//  Description : Bundles the command side and the result side of the ALU
//                result capture stage.
//                  master : upstream command source and downstream consumer
//                           (drives cmd_* / ALU result buses / res_ready)
//                  slave  : the capture FIFO itself
//                Port summary (slave view):
//                  in  cmd_valid, cmd_op[2:0], div_b[30:0]
//                  in  sum_i, dif_i, pro_i, quo_i, rem_i, and_i, or_i, xor_i
//                  out cmd_ready
//                  out res_valid, res_data[DW-1:0], res_op[2:0], res_err
//                  in  res_ready
//                  out fifo_count[AW:0], accept_cnt[15:0]
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_result_fifo_if #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);

  // Command side
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [30:0]   div_b;
  logic [DW-1:0] sum_i;
  logic [DW-1:0] dif_i;
  logic [DW-1:0] pro_i;
  logic [DW-1:0] quo_i;
  logic [DW-1:0] rem_i;
  logic [DW-1:0] and_i;
  logic [DW-1:0] or_i;
  logic [DW-1:0] xor_i;

  // Result side
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic [2:0]    res_op;
  logic          res_err;

  // Status
  logic [AW:0]   fifo_count;
  logic [15:0]   accept_cnt;

  modport master (
    output cmd_valid, cmd_op, div_b,
    output sum_i, dif_i, pro_i, quo_i, rem_i, and_i, or_i, xor_i,
    output res_ready,
    input  cmd_ready,
    input  res_valid, res_data, res_op, res_err,
    input  fifo_count, accept_cnt
  );

  modport slave (
    input  cmd_valid, cmd_op, div_b,
    input  sum_i, dif_i, pro_i, quo_i, rem_i, and_i, or_i, xor_i,
    input  res_ready,
    output cmd_ready,
    output res_valid, res_data, res_op, res_err,
    output fifo_count, accept_cnt
  );
endinterface
`default_nettype wire

// File: rtl/alu_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : alu_result_fifo
//  Description : Capture stage behind the combinational ALU. On each accepted
//                command the result bus chosen by cmd_op is stored together
//                with the opcode and a divide-by-zero flag in a DEPTH-entry
//                FIFO, which is presented to the consumer over valid/ready.
//                Ports:
//                  clk    : rising-edge clock
//                  rst_n  : asynchronous active-low reset
//                  bus    : alu_result_fifo_if.slave (command, result and
//                           status signals)
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_result_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  alu_result_fifo_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = DW + 4;  // {op[2:0], err, data[DW-1:0]}

  localparam logic [AW:0] c_DEPTH_CNT = (AW+1)'(DEPTH);

  localparam logic [2:0] c_OP_SUM = 3'd0;
  localparam logic [2:0] c_OP_DIF = 3'd1;
  localparam logic [2:0] c_OP_PRO = 3'd2;
  localparam logic [2:0] c_OP_QUO = 3'd3;
  localparam logic [2:0] c_OP_REM = 3'd4;
  localparam logic [2:0] c_OP_AND = 3'd5;
  localparam logic [2:0] c_OP_OR  = 3'd6;
  localparam logic [2:0] c_OP_XOR = 3'd7;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [15:0]   r_accept_cnt;
  logic [EW-1:0] r_mem [DEPTH];

  // --------------------------------------------------------------------------
  // Handshakes
  // --------------------------------------------------------------------------
  logic w_res_valid;
  logic w_cmd_ready;
  logic w_push;
  logic w_pop;

  assign w_res_valid = (r_count != '0);
  // A full FIFO can still take a command when the head leaves this cycle;
  // this is the only combinational path through the block (res_ready).
  assign w_cmd_ready = (r_count < c_DEPTH_CNT) || bus.res_ready;
  assign w_push      = bus.cmd_valid && w_cmd_ready;
  assign w_pop       = w_res_valid && bus.res_ready;

  // --------------------------------------------------------------------------
  // Result select and divide-by-zero detection
  // --------------------------------------------------------------------------
  logic [DW-1:0] w_sel;
  logic          w_is_div;
  logic          w_err;
  logic [DW-1:0] w_data;
  logic [EW-1:0] w_entry;

  always_comb begin
    w_sel = '0;
    case (bus.cmd_op)
      c_OP_SUM: w_sel = bus.sum_i;
      c_OP_DIF: w_sel = bus.dif_i;
      c_OP_PRO: w_sel = bus.pro_i;
      c_OP_QUO: w_sel = bus.quo_i;
      c_OP_REM: w_sel = bus.rem_i;
      c_OP_AND: w_sel = bus.and_i;
      c_OP_OR:  w_sel = bus.or_i;
      c_OP_XOR: w_sel = bus.xor_i;
      default:  w_sel = '0;
    endcase
  end

  assign w_is_div = (bus.cmd_op == c_OP_QUO) || (bus.cmd_op == c_OP_REM);
  assign w_err    = w_is_div && (bus.div_b == '0);
  // Whatever the ALU shows on a zero divide is meaningless; store zero.
  assign w_data   = w_err ? '0 : w_sel;
  assign w_entry  = {bus.cmd_op, w_err, w_data};

  // --------------------------------------------------------------------------
  // Storage: no reset, contents are only visible while res_valid is high.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  // --------------------------------------------------------------------------
  // Pointers, occupancy and accept counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_accept_cnt <= '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is modulo DEPTH.
      if (w_push) begin
        r_wr_ptr     <= r_wr_ptr + 1'b1;
        r_accept_cnt <= r_accept_cnt + 16'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: head entry is read straight from storage, forced to zero while
  // empty so stale contents never leak out.
  // --------------------------------------------------------------------------
  logic [EW-1:0] w_head;

  assign w_head = w_res_valid ? r_mem[r_rd_ptr] : '0;

  assign bus.cmd_ready  = w_cmd_ready;
  assign bus.res_valid  = w_res_valid;
  assign bus.res_op     = w_head[EW-1 -: 3];
  assign bus.res_err    = w_head[DW];
  assign bus.res_data   = w_head[DW-1:0];
  assign bus.fifo_count = r_count;
  assign bus.accept_cnt = r_accept_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_result_fifo
//  Description : Self-checking bench for alu_result_fifo. A queue-based
//                reference model tracks stored entries, occupancy and the
//                accept counter; every cycle the DUT outputs are compared
//                against it, plus directed constant checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_result_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [2:0]    op;
    logic          err;
    logic [DW-1:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  alu_result_fifo_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

  alu_result_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference model
  ent_t        m_q[$];
  logic [15:0] m_acc;
  logic [DW-1:0] vals [8];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic rand_vals();
    for (int i = 0; i < 8; i++) vals[i] = $urandom;
  endtask

  // One clock cycle. Called just after a falling edge; returns just after the
  // next falling edge.
  task automatic step(input logic v, input logic [2:0] op, input logic [30:0] b,
                      input logic rr);
    logic exp_ready;
    logic push;
    logic pop;
    ent_t e;
    bus.cmd_valid = v;
    bus.cmd_op    = op;
    bus.div_b     = b;
    bus.sum_i     = vals[0];
    bus.dif_i     = vals[1];
    bus.pro_i     = vals[2];
    bus.quo_i     = vals[3];
    bus.rem_i     = vals[4];
    bus.and_i     = vals[5];
    bus.or_i      = vals[6];
    bus.xor_i     = vals[7];
    bus.res_ready = rr;
    #1;
    exp_ready = (m_q.size() < DEPTH) || rr;
    check("cmd_ready",  64'(bus.cmd_ready),  64'(exp_ready));
    check("res_valid",  64'(bus.res_valid),  64'(m_q.size() != 0));
    check("fifo_count", 64'(bus.fifo_count), 64'(m_q.size()));
    check("accept_cnt", 64'(bus.accept_cnt), 64'(m_acc));
    if (m_q.size() != 0) begin
      check("res_data", 64'(bus.res_data), 64'(m_q[0].data));
      check("res_op",   64'(bus.res_op),   64'(m_q[0].op));
      check("res_err",  64'(bus.res_err),  64'(m_q[0].err));
    end else begin
      check("empty_head", 64'({bus.res_op, bus.res_err, bus.res_data}), 64'(0));
    end
    push = v && exp_ready;
    pop  = (m_q.size() != 0) && rr;
    e.op   = op;
    e.err  = ((op == 3'd3) || (op == 3'd4)) && (b == 31'd0);
    e.data = e.err ? '0 : vals[op];
    @(posedge clk);
    if (pop)  void'(m_q.pop_front());
    if (push) begin
      m_q.push_back(e);
      m_acc = m_acc + 16'd1;
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.div_b     = '0;
    bus.res_ready = 1'b0;
    for (int i = 0; i < 8; i++) vals[i] = '0;
    bus.sum_i = '0; bus.dif_i = '0; bus.pro_i = '0; bus.quo_i = '0;
    bus.rem_i = '0; bus.and_i = '0; bus.or_i = '0; bus.xor_i = '0;
    m_acc = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_cmd_ready",  64'(bus.cmd_ready),  64'(1));
    check("rst_res_valid",  64'(bus.res_valid),  64'(0));
    check("rst_fifo_count", 64'(bus.fifo_count), 64'(0));
    check("rst_accept_cnt", 64'(bus.accept_cnt), 64'(0));
    rst_n = 1'b1;

    // First push: sum = 7
    vals[0] = 32'h0000_0007;
    step(1'b1, 3'd0, 31'd5, 1'b0);
    check("p1_data",  64'(bus.res_data),   64'h7);
    check("p1_valid", 64'(bus.res_valid),  64'(1));
    check("p1_op",    64'(bus.res_op),     64'(0));
    check("p1_count", 64'(bus.fifo_count), 64'(1));
    check("p1_acc",   64'(bus.accept_cnt), 64'(1));

    // Divide by zero vs logic op with div_b = 0
    vals[3] = 32'hDEAD_BEEF;
    vals[5] = 32'hF0F0_F0F0;
    step(1'b1, 3'd3, 31'd0, 1'b1);   // pops the sum entry
    check("dz_err",  64'(bus.res_err),  64'(1));
    check("dz_data", 64'(bus.res_data), 64'(0));
    step(1'b1, 3'd5, 31'd0, 1'b1);
    check("and_err",  64'(bus.res_err),  64'(0));
    check("and_data", 64'(bus.res_data), 64'hF0F0_F0F0);
    step(1'b0, 3'd0, 31'd0, 1'b1);   // drain

    // Fill with res_ready low: 4 accepted, 5th held off
    for (int i = 0; i < 5; i++) begin
      rand_vals();
      step(1'b1, 3'($urandom_range(0, 7)), 31'($urandom), 1'b0);
    end
    check("full_count", 64'(bus.fifo_count), 64'(4));
    check("full_ready", 64'(bus.cmd_ready),  64'(0));
    // 8 cycles of simultaneous push and pop while full
    for (int i = 0; i < 8; i++) begin
      rand_vals();
      step(1'b1, 3'($urandom_range(0, 7)), 31'($urandom_range(0, 1)), 1'b1);
      check("full_pp_count", 64'(bus.fifo_count), 64'(4));
    end
    for (int i = 0; i < 5; i++) step(1'b0, 3'd0, 31'd0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_vals();
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 3) == 0) ? 31'd0 : 31'($urandom),
           1'($urandom_range(0, 2) == 0));
    end

    // Asynchronous reset with three entries stored
    for (int i = 0; i < 6; i++) step(1'b0, 3'd0, 31'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      rand_vals();
      step(1'b1, 3'd6, 31'd1, 1'b0);
    end
    check("pre_rst_count", 64'(bus.fifo_count), 64'(3));
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(bus.res_valid),  64'(0));
    check("arst_count", 64'(bus.fifo_count), 64'(0));
    check("arst_acc",   64'(bus.accept_cnt), 64'(0));
    m_q.delete();
    m_acc = '0;
    @(negedge clk);
    rst_n = 1'b1;
    vals[7] = 32'h1234_5678;
    step(1'b1, 3'd7, 31'd9, 1'b0);
    check("post_rst_count", 64'(bus.fifo_count), 64'(1));
    check("post_rst_data",  64'(bus.res_data),   64'h1234_5678);
    step(1'b0, 3'd0, 31'd0, 1'b1);
    check("post_rst_empty", 64'(bus.res_valid), 64'(0));

    // Accept counter wrap: reset, then 65537 pushes
    rst_n = 1'b0;
    m_q.delete();
    m_acc = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      vals[1] = 32'(i);
      step(1'b1, 3'd1, 31'd0, 1'b1);
    end
    check("acc_wrap", 64'(bus.accept_cnt), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
